seq_detect_fsm: RTL and testbench

//  Parametrised multi-sequence recogniser: NUM_SEQ_G fixed symbol sequences of SEQ_LEN_G symbols each.

---
 rtl/seq_detect_pkg.sv | 27 ++
 rtl/seq_detect_next.sv | 140 ++++++++++++++
 rtl/seq_detect_fsm.sv | 158 +++++++++++++++
 tb/tb_seq_detect_fsm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
// Shared types and helpers for the multi-sequence recogniser.
//   state_e     : FSM state encoding, also exported on state_o
//   err_cause_e : reason for the most recent error, exported on err_cause_o
//   clog2_min1  : $clog2 that never returns 0, so that every derived vector
//                 is at least one bit wide even for degenerate parameters
// ---------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISMATCH = 2'd1,
        TIMEOUT  = 2'd2
    } err_cause_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_detect_next.sv
// ---------------------------------------------------------------------------
// seq_detect_next
// Purely combinational next-state logic for seq_detect_fsm: header search,
// step comparison, inactivity timeout and ERROR hold sequencing.
// Ports:
//   state_q/seq_id_q/step_q/idle_q/hold_q : current register values
//   data_i, acc_i                          : current symbol and accept strobe
//   state_d/seq_id_d/step_d/idle_d/hold_d : next register values
//   match_d                                : last symbol of a sequence accepted
//   error_d, cause_d                       : entering ERROR and the reason
// ---------------------------------------------------------------------------
module seq_detect_next
    import seq_detect_pkg::*;
#(
    parameter int IO_SIZE_G  = 3,
    parameter int NUM_SEQ_G  = 2,
    parameter int SEQ_LEN_G  = 3,
    parameter logic [NUM_SEQ_G-1:0][SEQ_LEN_G-1:0][IO_SIZE_G-1:0] SEQ_TABLE_G =
        {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
    parameter int TIMEOUT_G  = 16,
    parameter int ERR_HOLD_G = 2
) (
    input  state_e                                     state_q,
    input  logic [clog2_min1(NUM_SEQ_G)-1:0]           seq_id_q,
    input  logic [clog2_min1(SEQ_LEN_G)-1:0]           step_q,
    input  logic [clog2_min1(TIMEOUT_G+1)-1:0]         idle_q,
    input  logic [clog2_min1(ERR_HOLD_G)-1:0]          hold_q,
    input  logic [IO_SIZE_G-1:0]                       data_i,
    input  logic                                       acc_i,
    output state_e                                     state_d,
    output logic [clog2_min1(NUM_SEQ_G)-1:0]           seq_id_d,
    output logic [clog2_min1(SEQ_LEN_G)-1:0]           step_d,
    output logic [clog2_min1(TIMEOUT_G+1)-1:0]         idle_d,
    output logic [clog2_min1(ERR_HOLD_G)-1:0]          hold_d,
    output logic                                       match_d,
    output logic                                       error_d,
    output err_cause_e                                 cause_d
);

    localparam int ID_W   = clog2_min1(NUM_SEQ_G);
    localparam int STEP_W = clog2_min1(SEQ_LEN_G);
    localparam int IDLE_W = clog2_min1(TIMEOUT_G + 1);
    localparam int HOLD_W = clog2_min1(ERR_HOLD_G);

    logic              hdr_hit;
    logic [ID_W-1:0]   hdr_idx;
    logic [IO_SIZE_G-1:0] exp_sym;

    // Header search runs from the top index down so the lowest matching
    // sequence is the one left in hdr_idx.
    always_comb begin
        hdr_hit = 1'b0;
        hdr_idx = '0;
        for (int k = NUM_SEQ_G - 1; k >= 0; k--) begin
            if (data_i == SEQ_TABLE_G[k][0]) begin
                hdr_hit = 1'b1;
                hdr_idx = ID_W'(k);
            end
        end
    end

    assign exp_sym = SEQ_TABLE_G[seq_id_q][step_q];

    // seq_id/step are forced to zero whenever the FSM is not tracking, so
    // the exported values need no extra masking in the top level.
    always_comb begin
        state_d  = state_q;
        seq_id_d = seq_id_q;
        step_d   = step_q;
        idle_d   = '0;
        hold_d   = '0;
        match_d  = 1'b0;
        error_d  = 1'b0;
        cause_d  = NONE;

        case (state_q)
            IDLE: begin
                seq_id_d = '0;
                step_d   = '0;
                if (acc_i && hdr_hit) begin
                    state_d  = TRACK;
                    seq_id_d = hdr_idx;
                    step_d   = STEP_W'(1);
                end
            end

            TRACK: begin
                if (acc_i) begin
                    if (data_i == exp_sym) begin
                        if (step_q == STEP_W'(SEQ_LEN_G - 1)) begin
                            state_d  = IDLE;
                            match_d  = 1'b1;
                            seq_id_d = '0;
                            step_d   = '0;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end else begin
                        state_d  = ERROR;
                        error_d  = 1'b1;
                        cause_d  = MISMATCH;
                        seq_id_d = '0;
                        step_d   = '0;
                    end
                end else if (TIMEOUT_G != 0) begin
                    // Fire on the idle cycle that would bring the count to TIMEOUT_G.
                    if (idle_q == IDLE_W'(TIMEOUT_G - 1)) begin
                        state_d  = ERROR;
                        error_d  = 1'b1;
                        cause_d  = TIMEOUT;
                        seq_id_d = '0;
                        step_d   = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end

            ERROR: begin
                seq_id_d = '0;
                step_d   = '0;
                if (hold_q == HOLD_W'(ERR_HOLD_G - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                // Unused encoding: recover through ERROR like a mismatch.
                state_d  = ERROR;
                error_d  = 1'b1;
                cause_d  = MISMATCH;
                seq_id_d = '0;
                step_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/seq_detect_fsm.sv
// ---------------------------------------------------------------------------
// seq_detect_fsm
// Multi-sequence recogniser with valid/ready input, inactivity timeout,
// timed ERROR hold and saturating match/error counters. One instance is one
// replica of a TMR-voted group.
// Ports:
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   clear_i          : synchronous clear of both counters (wins over increment)
//   data_i, valid_i  : input symbol and its valid strobe
//   ready_o          : low only while in ERROR
//   state_o          : current state_e
//   seq_id_o, step_o : tracked sequence and next expected index (0 outside TRACK)
//   match_o, match_id_o : one-cycle completion pulse and sequence id
//   error_o          : one-cycle pulse on entry to ERROR
//   err_cause_o      : cause of the last error, held
//   match_cnt_o, err_cnt_o : saturating event counters
// ---------------------------------------------------------------------------
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int IO_SIZE_G  = 3,
    parameter int NUM_SEQ_G  = 2,
    parameter int SEQ_LEN_G  = 3,
    parameter logic [NUM_SEQ_G-1:0][SEQ_LEN_G-1:0][IO_SIZE_G-1:0] SEQ_TABLE_G =
        {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
    parameter int TIMEOUT_G  = 16,
    parameter int ERR_HOLD_G = 2,
    parameter int CNT_W_G    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              clear_i,
    input  logic [IO_SIZE_G-1:0]              data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic [1:0]                        state_o,
    output logic [clog2_min1(NUM_SEQ_G)-1:0]  seq_id_o,
    output logic [clog2_min1(SEQ_LEN_G)-1:0]  step_o,
    output logic                              match_o,
    output logic [clog2_min1(NUM_SEQ_G)-1:0]  match_id_o,
    output logic                              error_o,
    output logic [1:0]                        err_cause_o,
    output logic [CNT_W_G-1:0]                match_cnt_o,
    output logic [CNT_W_G-1:0]                err_cnt_o
);

    localparam int ID_W   = clog2_min1(NUM_SEQ_G);
    localparam int STEP_W = clog2_min1(SEQ_LEN_G);
    localparam int IDLE_W = clog2_min1(TIMEOUT_G + 1);
    localparam int HOLD_W = clog2_min1(ERR_HOLD_G);

    state_e             state_q,    state_d;
    logic [ID_W-1:0]    seq_id_q,   seq_id_d;
    logic [STEP_W-1:0]  step_q,     step_d;
    logic [IDLE_W-1:0]  idle_q,     idle_d;
    logic [HOLD_W-1:0]  hold_q,     hold_d;
    logic               match_q,    match_d;
    logic [ID_W-1:0]    match_id_q, match_id_d;
    logic               error_q,    error_d;
    err_cause_e         err_cause_q, err_cause_d;
    err_cause_e         cause_d;
    logic [CNT_W_G-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W_G-1:0] err_cnt_q,   err_cnt_d;
    logic               acc;

    // ready is decoded straight from the state flop so it is high in reset.
    assign ready_o = (state_q != ERROR);
    assign acc     = valid_i & ready_o;

    seq_detect_next #(
        .IO_SIZE_G   (IO_SIZE_G),
        .NUM_SEQ_G   (NUM_SEQ_G),
        .SEQ_LEN_G   (SEQ_LEN_G),
        .SEQ_TABLE_G (SEQ_TABLE_G),
        .TIMEOUT_G   (TIMEOUT_G),
        .ERR_HOLD_G  (ERR_HOLD_G)
    ) u_next (
        .state_q  (state_q),
        .seq_id_q (seq_id_q),
        .step_q   (step_q),
        .idle_q   (idle_q),
        .hold_q   (hold_q),
        .data_i   (data_i),
        .acc_i    (acc),
        .state_d  (state_d),
        .seq_id_d (seq_id_d),
        .step_d   (step_d),
        .idle_d   (idle_d),
        .hold_d   (hold_d),
        .match_d  (match_d),
        .error_d  (error_d),
        .cause_d  (cause_d)
    );

    // Output side-band and saturating counters; clear beats a same-cycle event.
    always_comb begin
        match_id_d  = '0;
        err_cause_d = err_cause_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (match_d) begin
            match_id_d = seq_id_q;
        end
        if (error_d) begin
            err_cause_d = cause_d;
        end
        if (clear_i) begin
            match_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            if (match_d && (match_cnt_q != '1)) begin
                match_cnt_d = match_cnt_q + CNT_W_G'(1);
            end
            if (error_d && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W_G'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            seq_id_q    <= '0;
            step_q      <= '0;
            idle_q      <= '0;
            hold_q      <= '0;
            match_q     <= 1'b0;
            match_id_q  <= '0;
            error_q     <= 1'b0;
            err_cause_q <= NONE;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            seq_id_q    <= seq_id_d;
            step_q      <= step_d;
            idle_q      <= idle_d;
            hold_q      <= hold_d;
            match_q     <= match_d;
            match_id_q  <= match_id_d;
            error_q     <= error_d;
            err_cause_q <= err_cause_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign seq_id_o    = seq_id_q;
    assign step_o      = step_q;
    assign match_o     = match_q;
    assign match_id_o  = match_id_q;
    assign error_o     = error_q;
    assign err_cause_o = err_cause_q;
    assign match_cnt_o = match_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_fsm
// Directed bench for seq_detect_fsm. Two replicas share all inputs: one with
// default parameters, one with 2-bit counters to exercise saturation.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
// ---------------------------------------------------------------------------
module tb_seq_detect_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [2:0]  data;
    logic        valid;

    logic        ready,    s_ready;
    logic [1:0]  state,    s_state;
    logic [0:0]  seq_id,   s_seq_id;
    logic [1:0]  step,     s_step;
    logic        match,    s_match;
    logic [0:0]  match_id, s_match_id;
    logic        error,    s_error;
    logic [1:0]  cause,    s_cause;
    logic [15:0] mcnt,     ecnt;
    logic [1:0]  s_mcnt,   s_ecnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_fsm dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .data_i(data), .valid_i(valid),
        .ready_o(ready), .state_o(state), .seq_id_o(seq_id), .step_o(step),
        .match_o(match), .match_id_o(match_id), .error_o(error), .err_cause_o(cause),
        .match_cnt_o(mcnt), .err_cnt_o(ecnt)
    );

    seq_detect_fsm #(.CNT_W_G(2)) dut_small (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .data_i(data), .valid_i(valid),
        .ready_o(s_ready), .state_o(s_state), .seq_id_o(s_seq_id), .step_o(s_step),
        .match_o(s_match), .match_id_o(s_match_id), .error_o(s_error), .err_cause_o(s_cause),
        .match_cnt_o(s_mcnt), .err_cnt_o(s_ecnt)
    );

    // Present one symbol for one clock and return at the following falling edge.
    task automatic applyStimulus(input logic v, input logic [2:0] d);
        valid = v;
        data  = d;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        data  = 3'd0;
        valid = 1'b0;

        // Reset values, ready high while in reset
        #3;
        checkOutput("rst_state",  32'(state),  32'd0);
        checkOutput("rst_ready",  32'(ready),  32'd1);
        checkOutput("rst_match",  32'(match),  32'd0);
        checkOutput("rst_error",  32'(error),  32'd0);
        checkOutput("rst_cause",  32'(cause),  32'd0);
        checkOutput("rst_mcnt",   32'(mcnt),   32'd0);
        checkOutput("rst_ecnt",   32'(ecnt),   32'd0);
        checkOutput("rst_seq_id", 32'(seq_id), 32'd0);
        checkOutput("rst_step",   32'(step),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: sequence 0 back-to-back
        applyStimulus(1'b1, 3'd1);
        checkOutput("t1_state_track", 32'(state),  32'd1);
        checkOutput("t1_seq_id",      32'(seq_id), 32'd0);
        checkOutput("t1_step1",       32'(step),   32'd1);
        checkOutput("t1_no_match",    32'(match),  32'd0);
        applyStimulus(1'b1, 3'd2);
        checkOutput("t1_step2",       32'(step),   32'd2);
        applyStimulus(1'b1, 3'd3);
        checkOutput("t1_match",       32'(match),    32'd1);
        checkOutput("t1_match_id",    32'(match_id), 32'd0);
        checkOutput("t1_mcnt",        32'(mcnt),     32'd1);
        checkOutput("t1_ecnt",        32'(ecnt),     32'd0);
        checkOutput("t1_state_idle",  32'(state),    32'd0);
        checkOutput("t1_step_idle",   32'(step),     32'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("t1_match_pulse", 32'(match),    32'd0);
        checkOutput("t1_mcnt_hold",   32'(mcnt),     32'd1);

        // 2: mismatch in sequence 1, two-cycle ERROR hold
        applyStimulus(1'b1, 3'd4);
        checkOutput("t2_state_track", 32'(state),  32'd1);
        checkOutput("t2_seq_id",      32'(seq_id), 32'd1);
        checkOutput("t2_step1",       32'(step),   32'd1);
        applyStimulus(1'b1, 3'd5);
        checkOutput("t2_step2",       32'(step),   32'd2);
        applyStimulus(1'b1, 3'd7);
        checkOutput("t2_state_err",   32'(state),  32'd2);
        checkOutput("t2_error",       32'(error),  32'd1);
        checkOutput("t2_cause",       32'(cause),  32'd1);
        checkOutput("t2_ready0",      32'(ready),  32'd0);
        checkOutput("t2_ecnt",        32'(ecnt),   32'd1);
        checkOutput("t2_seq_id_zero", 32'(seq_id), 32'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("t2_hold_state",  32'(state),  32'd2);
        checkOutput("t2_error_pulse", 32'(error),  32'd0);
        checkOutput("t2_ready1",      32'(ready),  32'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("t2_back_idle",   32'(state),  32'd0);
        checkOutput("t2_ready_back",  32'(ready),  32'd1);
        checkOutput("t2_cause_held",  32'(cause),  32'd1);

        // 3: 16 idle cycles time out, 15 do not
        applyStimulus(1'b1, 3'd1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 3'd0);
        end
        checkOutput("t3_still_track", 32'(state), 32'd1);
        checkOutput("t3_no_error",    32'(error), 32'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("t3_to_state",    32'(state), 32'd2);
        checkOutput("t3_to_error",    32'(error), 32'd1);
        checkOutput("t3_to_cause",    32'(cause), 32'd2);
        checkOutput("t3_to_ecnt",     32'(ecnt),  32'd2);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("t3_idle",        32'(state), 32'd0);
        applyStimulus(1'b1, 3'd1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 3'd0);
        end
        checkOutput("t3_gap15_track", 32'(state), 32'd1);
        checkOutput("t3_gap15_step",  32'(step),  32'd1);
        applyStimulus(1'b1, 3'd2);
        applyStimulus(1'b1, 3'd3);
        checkOutput("t3_gap_match",   32'(match), 32'd1);
        checkOutput("t3_gap_mcnt",    32'(mcnt),  32'd2);
        checkOutput("t3_gap_ecnt",    32'(ecnt),  32'd2);

        // 4: two sequences with no gap, then non-header symbols in IDLE
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd2);
        applyStimulus(1'b1, 3'd3);
        checkOutput("t4_match0",      32'(match),    32'd1);
        checkOutput("t4_match0_id",   32'(match_id), 32'd0);
        checkOutput("t4_mcnt3",       32'(mcnt),     32'd3);
        applyStimulus(1'b1, 3'd4);
        checkOutput("t4_b2b_nomatch", 32'(match),  32'd0);
        checkOutput("t4_b2b_state",   32'(state),  32'd1);
        checkOutput("t4_b2b_seq_id",  32'(seq_id), 32'd1);
        applyStimulus(1'b1, 3'd5);
        applyStimulus(1'b1, 3'd6);
        checkOutput("t4_match1",      32'(match),    32'd1);
        checkOutput("t4_match1_id",   32'(match_id), 32'd1);
        checkOutput("t4_mcnt4",       32'(mcnt),     32'd4);
        checkOutput("t4_small_sat",   32'(s_mcnt),   32'd3);
        applyStimulus(1'b1, 3'd0);
        checkOutput("t4_junk0_state", 32'(state), 32'd0);
        applyStimulus(1'b1, 3'd7);
        checkOutput("t4_junk7_state", 32'(state), 32'd0);
        checkOutput("t4_junk7_error", 32'(error), 32'd0);
        applyStimulus(1'b1, 3'd0);
        checkOutput("t4_junk_ecnt",   32'(ecnt),  32'd2);
        checkOutput("t4_junk_error",  32'(error), 32'd0);

        // 5: saturation on the 2-bit replica, clear beats a same-cycle match
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd2);
        applyStimulus(1'b1, 3'd3);
        checkOutput("t5_mcnt5",       32'(mcnt),   32'd5);
        checkOutput("t5_small_sat",   32'(s_mcnt), 32'd3);
        checkOutput("t5_small_ecnt",  32'(s_ecnt), 32'd2);
        applyStimulus(1'b1, 3'd4);
        applyStimulus(1'b1, 3'd5);
        clear = 1'b1;
        applyStimulus(1'b1, 3'd6);
        clear = 1'b0;
        checkOutput("t5_clr_match",   32'(match),  32'd1);
        checkOutput("t5_clr_mcnt",    32'(mcnt),   32'd0);
        checkOutput("t5_clr_ecnt",    32'(ecnt),   32'd0);
        checkOutput("t5_clr_small",   32'(s_mcnt), 32'd0);

        // 6: asynchronous reset in the middle of a sequence
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd2);
        applyStimulus(1'b1, 3'd3);
        checkOutput("t6_mcnt1",       32'(mcnt),  32'd1);
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd2);
        checkOutput("t6_pre_state",   32'(state), 32'd1);
        checkOutput("t6_pre_step",    32'(step),  32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_state", 32'(state),  32'd0);
        checkOutput("t6_async_step",  32'(step),   32'd0);
        checkOutput("t6_async_mcnt",  32'(mcnt),   32'd0);
        checkOutput("t6_async_ecnt",  32'(ecnt),   32'd0);
        checkOutput("t6_async_error", 32'(error),  32'd0);
        checkOutput("t6_async_ready", 32'(ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0);
        checkOutput("t6_post_state",  32'(state), 32'd0);
        checkOutput("t6_post_error",  32'(error), 32'd0);
        checkOutput("t6_post_cause",  32'(cause), 32'd0);
        checkOutput("t6_post_ecnt",   32'(ecnt),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
